rr_channel_mux: RTL and testbench
=================================

RR_CHANNEL_MUX -- requirements
Module: rr_channel_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per channel (1..64).
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 SHALL derive localparam SELW = clog2(CHANNELS), select/pointer width.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port mode  input  1  0 = fixed select via sel, 1 = round-robin.
REQ-007 SHALL have port sel  input  SELW  channel index used when mode=0.
REQ-008 SHALL have port in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid  input  CHANNELS  per-channel word available.
REQ-010 SHALL have port in_ready  output  CHANNELS  per-channel word accepted this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-012 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready  input  1  downstream consumes word when out_valid=1.
REQ-014 SHALL have port out_ch  output  SELW  source channel index of out_data.

Function
REQ-015 SHALL hold a one-entry output register (out_data, out_ch, out_valid) plus a round-robin pointer ptr (SELW bits).
REQ-016 SHALL compute can_accept = !out_valid || out_ready, combinationally.
REQ-017 Mode 0: grant = sel if sel < CHANNELS and in_valid[sel]=1; otherwise no grant; in_valid of other channels ignored.
REQ-018 Mode 1: grant = first channel with in_valid=1 searching ptr+1, ptr+2, ... wrapping modulo CHANNELS, ptr itself searched last; no grant if no in_valid set.
REQ-019 in_ready[i] SHALL be 1 only when i is granted and can_accept=1; at most one in_ready bit high per cycle; in_ready SHALL NOT depend on in_data.
REQ-020 On accept (grant exists, can_accept=1): next edge loads out_data = granted word, out_ch = grant, out_valid = 1; latency in_valid-to-out_valid = 1 cycle.
REQ-021 On out_valid=1, out_ready=1, no accept: next edge clears out_valid; out_data/out_ch hold last value.
REQ-022 Simultaneous drain and accept: new word loaded, out_valid stays 1, full throughput of one word per cycle.
REQ-023 out_valid=1, out_ready=0: out_data/out_ch/out_valid SHALL hold stable; all in_ready = 0.
REQ-024 ptr SHALL update to grant only on accept in mode 1; ptr SHALL hold in mode 0 and on no-accept cycles.
REQ-025 mode and sel are sampled combinationally each cycle; a change affects only the next accept, never a word already registered.
REQ-026 Wrap-around: with ptr = CHANNELS-1 the search SHALL start at channel 0.

Reset
REQ-027 While rst=1, regardless of clk: out_valid = 0, out_data = 0, out_ch = 0, ptr = CHANNELS-1 (first round-robin grant goes to channel 0).
REQ-028 in_ready SHALL be all-zero while rst=1.
REQ-029 Reset asserted mid-transfer SHALL discard the registered word; no word accepted in the reset cycle.
REQ-030 First accept possible on the first rising edge after rst deasserts.

Verification
REQ-031 Reset: rst=1 with out_valid=1 holding 0xA5 -> immediately out_valid=0, out_data=0, out_ch=0, in_ready=0000.
REQ-032 Fixed mode: mode=0, sel=2, in_valid=1111, ch2=0x3C, out_ready=1 -> in_ready=0100, next cycle out_data=0x3C, out_ch=2; ch0/1/3 never accepted.
REQ-033 Round-robin fairness: mode=1, in_valid=1111 held, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one word per cycle.
REQ-034 Skip and wrap: mode=1, ptr=1, in_valid=1001 -> grant ch3 then ch0, then ch3 again.
REQ-035 Backpressure: out_valid=1, out_data=0x11, out_ready=0 for 3 cycles with in_valid=1111 -> out_data stays 0x11, in_ready=0000, ptr unchanged; out_ready=1 -> next word accepted same cycle.
REQ-036 Out-of-range sel: CHANNELS=3, mode=0, sel=3, in_valid=111 -> no grant, in_ready=000, out_valid falls to 0 after drain.

Source files
------------

// File: rtl/rr_channel_mux.sv
// Multi-channel valid/ready mux into a one-entry output register.
// Channels are picked either by a fixed select or by a round-robin pointer.
module rr_channel_mux #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_ch
);

  logic [SELW-1:0]  ptr;
  logic             grant_valid;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] grant_data;
  logic             can_accept;
  logic             accept;

  always_comb begin : grant_search
    // NOTE: defaults first so every path assigns and no latch is inferred.
    grant_valid = 1'b0;
    grant       = '0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant       = SELW'(i);
        end
      end
    end else begin
      // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (i == (int'(ptr) + k) % CHANNELS && in_valid[i]) begin
            grant_valid = 1'b1;
            grant       = SELW'(i);
          end
        end
      end
    end
  end

  always_comb begin : data_select
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign can_accept = !out_valid || out_ready;
  assign accept     = grant_valid && can_accept && !rst;

  always_comb begin : ready_decode
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = accept && (grant == SELW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(CHANNELS - 1);
    end else if (accept) begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant;
      if (mode) ptr <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));

endmodule

// File: tb/tb_rr_channel_mux.sv
// Scoreboard bench for rr_channel_mux: a 4-channel instance driven by a reference
// model plus directed scenarios, and a 3-channel instance for out-of-range select.
module tb_rr_channel_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  logic        m3_mode;
  logic [1:0]  m3_sel;
  logic [23:0] m3_in_data;
  logic [2:0]  m3_in_valid;
  logic [2:0]  m3_in_ready;
  logic [7:0]  m3_out_data;
  logic        m3_out_valid;
  logic        m3_out_ready;
  logic [1:0]  m3_out_ch;

  rr_channel_mux #(.WIDTH(8), .CHANNELS(4)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  rr_channel_mux #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst(rst), .mode(m3_mode), .sel(m3_sel), .in_data(m3_in_data),
    .in_valid(m3_in_valid), .in_ready(m3_in_ready), .out_data(m3_out_data),
    .out_valid(m3_out_valid), .out_ready(m3_out_ready), .out_ch(m3_out_ch)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
  } word_t;

  word_t      sb[$];
  int         mptr;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] obs_ready;
  int         obs_grant;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic void model_grant(input logic m, input int s, input logic [3:0] v,
                                      input int p, output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (!m) begin
      if (s < 4 && v[s]) begin
        gv = 1'b1;
        g  = s;
      end
    end else begin
      for (int k = 1; k <= 4 && !gv; k++) begin
        if (v[(p + k) % 4]) begin
          gv = 1'b1;
          g  = (p + k) % 4;
        end
      end
    end
  endfunction

  // One cycle: drive, compare against the model, then advance past the next edge.
  task automatic cycle(input logic m, input int s, input logic [3:0] v,
                       input logic [31:0] d, input logic ordy);
    bit         gv;
    int         g;
    bit         can;
    logic [3:0] er;
    word_t      e;
    mode      = m;
    sel       = 2'(s);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    model_grant(m, s, v, mptr, gv, g);
    can = (sb.size() == 0) || ordy;
    er  = (gv && can) ? 4'(1 << g) : 4'b0000;
    obs_ready = in_ready;
    obs_grant = -1;
    for (int i = 0; i < 4; i++) if (in_ready[i]) obs_grant = i;
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0 && ordy) begin
      e = sb.pop_front();
      check("out_data", out_data, e.data);
      check("out_ch", out_ch, e.ch);
    end
    if (gv && can) begin
      sb.push_back('{data: d[g*8 +: 8], ch: 2'(g)});
      if (m) mptr = g;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_sw[3];
    exp_sw = '{3, 0, 3};
    rst = 1'b1;
    mode = 1'b1; sel = 2'd0; in_valid = 4'b1111; in_data = 32'h0; out_ready = 1'b1;
    m3_mode = 1'b0; m3_sel = 2'd0; m3_in_valid = 3'b000; m3_in_data = 24'h0; m3_out_ready = 1'b1;
    mptr = 3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_ch", out_ch, 2'd0);
    check("rst_in_ready", in_ready, 4'b0000);
    rst = 1'b0;

    // Fixed select of channel 2
    cycle(1'b0, 2, 4'b1111, pack4(8'hA0, 8'hB1, 8'h3C, 8'hD3), 1'b1);
    check("fix_ready", obs_ready, 4'b0100);
    check("fix_data", out_data, 8'h3C);
    cycle(1'b0, 2, 4'b0000, 32'h0, 1'b1);

    // Round-robin fairness across all requesters
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 0, 4'b1111, pack4(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)), 1'b1);
      check("rr_seq", obs_grant, i % 4);
    end

    // Skip and wrap from ptr=1
    cycle(1'b1, 0, 4'b0010, pack4(8'h00, 8'h55, 8'h00, 8'h00), 1'b1);
    for (int j = 0; j < 3; j++) begin
      cycle(1'b1, 0, 4'b1001, pack4(8'(8'h60 + j), 8'h00, 8'h00, 8'(8'h70 + j)), 1'b1);
      check("skip_wrap", obs_grant, exp_sw[j]);
    end

    // Backpressure holding 0x11
    cycle(1'b1, 0, 4'b0001, pack4(8'h11, 8'h00, 8'h00, 8'h00), 1'b1);
    for (int j = 0; j < 3; j++) begin
      cycle(1'b1, 0, 4'b1111, pack4(8'h91, 8'h92, 8'h93, 8'h94), 1'b0);
      check("bp_ready", obs_ready, 4'b0000);
      check("bp_data", out_data, 8'h11);
    end
    cycle(1'b1, 0, 4'b1111, pack4(8'h91, 8'h92, 8'h93, 8'h94), 1'b1);
    check("bp_resume", obs_grant, 1);

    // Fixed-mode accept must leave the round-robin pointer alone
    cycle(1'b0, 3, 4'b1111, pack4(8'hC0, 8'hC1, 8'hC2, 8'hC3), 1'b1);
    cycle(1'b1, 0, 4'b1111, pack4(8'hE0, 8'hE1, 8'hE2, 8'hE3), 1'b1);
    check("ptr_hold", obs_grant, 2);

    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            $urandom, 1'($urandom_range(0, 3) != 0));
    end
    cycle(1'b1, 0, 4'b0000, 32'h0, 1'b1);
    cycle(1'b1, 0, 4'b0000, 32'h0, 1'b1);

    // Reset in the middle of a held transfer
    cycle(1'b1, 0, 4'b1111, pack4(8'hA5, 8'hA5, 8'hA5, 8'hA5), 1'b0);
    check("pre_rst_data", out_data, 8'hA5);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 8'h00);
    check("mid_rst_out_ch", out_ch, 2'd0);
    check("mid_rst_in_ready", in_ready, 4'b0000);
    sb.delete();
    mptr = 3;
    @(posedge clk);
    #1;
    check("rst_edge_valid", out_valid, 1'b0);
    rst = 1'b0;
    cycle(1'b1, 0, 4'b1111, pack4(8'h01, 8'h02, 8'h03, 8'h04), 1'b1);
    check("post_rst_grant", obs_grant, 0);
    cycle(1'b1, 0, 4'b0000, 32'h0, 1'b1);

    // Three-channel instance: out-of-range select never grants
    m3_mode = 1'b0; m3_sel = 2'd1; m3_in_valid = 3'b111; m3_in_data = 24'h7A_5B_3C;
    m3_out_ready = 1'b1;
    #1;
    check("m3_ready_sel1", m3_in_ready, 3'b010);
    @(posedge clk);
    #1;
    check("m3_valid", m3_out_valid, 1'b1);
    check("m3_data", m3_out_data, 8'h5B);
    m3_sel = 2'd3;
    #1;
    check("m3_ready_sel3", m3_in_ready, 3'b000);
    @(posedge clk);
    #1;
    check("m3_drained", m3_out_valid, 1'b0);
    check("m3_hold_data", m3_out_data, 8'h5B);
    check("m3_hold_ch", m3_out_ch, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
